// File: rtl/text_console_writer.sv
// text_console_writer: character-stream front end for the text-mode video RAM.
// It accepts ASCII bytes over a valid/ready handshake and tracks a cursor. It
// issues single-cycle write commands to the RAM write port and handles the
// CR, LF, BS and FF (clear screen) control codes.
//
// Ports:
//   clk         system clock, rising edge
//   rstn        synchronous active-low reset
//   char_in     incoming character code
//   char_valid  char_in valid
//   char_ready  block can accept char_in this cycle
//   ram_we      video RAM write strobe
//   ram_addr    video RAM address (row*cols+col, modulo 2**addr_width)
//   ram_din     video RAM write data
//   cursor_col  current column, 0..cols-1
//   cursor_row  current row, 0..rows-1
//   busy        high while a clear-screen sequence runs
module text_console_writer #(
  parameter int unsigned cols       = 40,
  parameter int unsigned rows       = 30,
  parameter int unsigned addr_width = 11,
  parameter int unsigned data_width = 8,
  parameter logic [data_width-1:0] FILL_CHAR = data_width'(8'h20),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [data_width-1:0] char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  output logic [5:0]            cursor_col,
  output logic [4:0]            cursor_row,
  output logic                  busy
);

  // One extra bit so the clear counter can hold rows*cols == 2**addr_width.
  localparam int unsigned CntW = addr_width + 1;

  localparam logic [5:0]            LastCol = 6'(cols - 1);
  localparam logic [4:0]            LastRow = 5'(rows - 1);
  localparam logic [CntW-1:0]       Total   = CntW'(rows * cols);
  localparam logic [addr_width-1:0] ColsA   = addr_width'(cols);

  localparam logic [data_width-1:0] ChBs    = data_width'(8'h08);
  localparam logic [data_width-1:0] ChLf    = data_width'(8'h0A);
  localparam logic [data_width-1:0] ChFf    = data_width'(8'h0C);
  localparam logic [data_width-1:0] ChCr    = data_width'(8'h0D);
  localparam logic [data_width-1:0] ChSpace = data_width'(8'h20);
  localparam logic [data_width-1:0] ChTilde = data_width'(8'h7E);

  typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

  state_e                state_q, state_d;
  logic [5:0]            col_q, col_d;
  logic [4:0]            row_q, row_d;
  // Running linear address, always equal to row_q*cols+col_q.
  logic [addr_width-1:0] lin_q, lin_d;
  // Next clear address to issue; reaching Total means the clear is done.
  logic [CntW-1:0]       clr_q, clr_d;
  logic                  we_q, we_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] din_q, din_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic [addr_width-1:0] col_ext;

  assign char_ready = rstn && (state_q == StIdle);
  assign accept     = char_valid && char_ready;
  assign col_ext    = addr_width'(col_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    lin_d   = lin_q;
    clr_d   = clr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (char_in >= ChSpace && char_in <= ChTilde) begin
            state_d = StWrite;
            we_d    = 1'b1;
            addr_d  = lin_q;
            din_d   = char_in;
            if (col_q == LastCol) begin
              col_d = 6'd0;
              if (row_q == LastRow) begin
                row_d = 5'd0;
                lin_d = '0;
              end else begin
                row_d = row_q + 5'd1;
                lin_d = lin_q + addr_width'(1);
              end
            end else begin
              col_d = col_q + 6'd1;
              lin_d = lin_q + addr_width'(1);
            end
          end else begin
            case (char_in)
              ChCr: begin
                col_d = 6'd0;
                lin_d = lin_q - col_ext;
              end
              ChLf: begin
                col_d = 6'd0;
                if (row_q == LastRow) begin
                  row_d = 5'd0;
                  lin_d = '0;
                end else begin
                  row_d = row_q + 5'd1;
                  lin_d = lin_q - col_ext + ColsA;
                end
              end
              ChBs: begin
                // Backspace never backs up into the previous row.
                if (col_q != 6'd0) begin
                  state_d = StWrite;
                  col_d   = col_q - 6'd1;
                  lin_d   = lin_q - addr_width'(1);
                  we_d    = 1'b1;
                  addr_d  = lin_q - addr_width'(1);
                  din_d   = FILL_CHAR;
                end
              end
              ChFf: begin
                // Address 0 is issued on the accepting edge so the clear spans
                // exactly rows*cols busy cycles.
                state_d = StClear;
                we_d    = 1'b1;
                addr_d  = '0;
                din_d   = FILL_CHAR;
                busy_d  = 1'b1;
                clr_d   = CntW'(1);
              end
              default: ;
            endcase
          end
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      StClear: begin
        if (clr_q == Total) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          col_d   = 6'd0;
          row_d   = 5'd0;
          lin_d   = '0;
        end else begin
          we_d   = 1'b1;
          addr_d = clr_q[addr_width-1:0];
          din_d  = FILL_CHAR;
          busy_d = 1'b1;
          clr_d  = clr_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= CLEAR_ON_RESET ? StClear : StIdle;
      col_q   <= 6'd0;
      row_q   <= 5'd0;
      lin_q   <= '0;
      clr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      lin_q   <= lin_d;
      clr_q   <= clr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
    end
  end

  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_din    = din_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Testbench for text_console_writer. A reference model computes the expected
// RAM writes and cursor position from the character semantics. It queues the
// writes, and a negedge monitor compares every ram_we cycle against that queue.
module tb_text_console_writer;

  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int FILL = 8'h20;

  logic        clk;
  logic        rstn;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  text_console_writer #(
    .cols(COLS),
    .rows(ROWS),
    .addr_width(11),
    .data_width(8),
    .FILL_CHAR(8'h20),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .char_in(char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  busy_cycles = 0;
  int  m_col = 0;
  int  m_row = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic void push_wr(input int addr, input int data);
    wr_t w;
    w.addr = addr % 2048;
    w.data = data;
    exp_q.push_back(w);
  endfunction

  // Reference model. Returns 1 when the character leaves the block non-idle.
  function automatic bit model(input logic [7:0] c);
    bit wr;
    wr = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_wr(m_row * COLS + m_col, int'(c));
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
      wr = 1'b1;
    end else begin
      case (c)
        8'h0D: m_col = 0;
        8'h0A: begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
        end
        8'h08: begin
          if (m_col > 0) begin
            m_col--;
            push_wr(m_row * COLS + m_col, FILL);
            wr = 1'b1;
          end
        end
        8'h0C: begin
          for (int i = 0; i < COLS * ROWS; i++) push_wr(i, FILL);
          m_col = 0;
          m_row = 0;
          wr = 1'b1;
        end
        default: ;
      endcase
    end
    return wr;
  endfunction

  // Monitor: every write the DUT issues must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (busy === 1'b1) busy_cycles++;
    if (ram_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%0h", ram_addr, ram_din);
      end else begin
        e = exp_q.pop_front();
        if (int'(ram_addr) != e.addr || int'(ram_din) != e.data) begin
          errors++;
          $display("FAIL ram_write actual addr=%0d data=%0h expected addr=%0d data=%0h",
                   ram_addr, ram_din, e.addr, e.data);
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge with char_ready high or timed out.
  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (char_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send(input logic [7:0] c);
    bit wr;
    wait_ready(3000);
    if (char_ready !== 1'b1) begin
      chk("ready_timeout", char_ready, 1);
      return;
    end
    wr = model(c);
    char_in    = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_in    = 8'($urandom);
    @(negedge clk);
    chk("ready_after_accept", char_ready, !wr);
    wait_ready(3000);
    chk("ready_return", char_ready, 1);
    chk("cursor_col", cursor_col, m_col);
    chk("cursor_row", cursor_row, m_row);
  endtask

  task automatic send_printable(input int n);
    for (int i = 0; i < n; i++) send(8'($urandom_range(8'h20, 8'h7E)));
  endtask

  task automatic send_lf(input int n);
    for (int i = 0; i < n; i++) send(8'h0A);
  endtask

  // Release reset at a negedge and expect a full automatic clear.
  task automatic release_and_clear(input string tag);
    for (int i = 0; i < COLS * ROWS; i++) push_wr(i, FILL);
    m_col = 0;
    m_row = 0;
    busy_cycles = 0;
    rstn = 1'b1;
    @(negedge clk);
    wait_ready(1500);
    chk({tag, "_ready"}, char_ready, 1);
    chk({tag, "_busy_cycles"}, busy_cycles, COLS * ROWS);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_cursor_col"}, cursor_col, 0);
    chk({tag, "_cursor_row"}, cursor_row, 0);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int r;
    logic [7:0] c;
    rstn       = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_we", ram_we, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", char_ready, 0);
    chk("reset_addr", ram_addr, 0);
    chk("reset_din", ram_din, 0);
    chk("reset_cursor_col", cursor_col, 0);
    chk("reset_cursor_row", cursor_row, 0);
    release_and_clear("init_clear");

    // Back-to-back printable characters.
    send(8'h41);
    send(8'h42);
    chk("ab_cursor_col", cursor_col, 2);

    // Full clear through FF.
    busy_cycles = 0;
    send(8'h0C);
    chk("ff_busy_cycles", busy_cycles, COLS * ROWS);

    // Last cell of the screen then wrap to the top.
    send_lf(29);
    send_printable(39);
    send(8'h5A);

    // Backspace at (5,3), then at column 0.
    send_lf(3);
    send_printable(5);
    send(8'h08);
    send(8'h0D);
    send(8'h08);

    // LF on the last row wraps, CR, and an ignored code.
    send_lf(26);
    send_printable(7);
    send(8'h0A);
    send_lf(2);
    send_printable(7);
    send(8'h0D);
    send(8'h07);

    // Randomized mix of printables, controls and ignored codes.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) c = 8'($urandom_range(8'h20, 8'h7E));
      else if (r == 6) c = 8'h0D;
      else if (r == 7) c = 8'h0A;
      else if (r == 8) c = 8'h08;
      else begin
        c = 8'($urandom_range(8'h7F, 8'hFF));
        if (c[0]) c = 8'($urandom_range(0, 7));
      end
      send(c);
    end

    // Reset in the middle of a clear.
    wait_ready(3000);
    void'(model(8'h0C));
    char_in    = 8'h0C;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    r = 0;
    @(negedge clk);
    while (!(ram_we === 1'b1 && ram_addr == 11'd500) && r < 2000) begin
      @(negedge clk);
      r++;
    end
    chk("clear_reached_500", ram_addr, 500);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("abort_we", ram_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", char_ready, 0);
    chk("abort_cursor_col", cursor_col, 0);
    chk("abort_cursor_row", cursor_row, 0);
    repeat (3) @(negedge clk);
    release_and_clear("restart_clear");

    send(8'h41);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Upstream character-stream front end for the text-mode video RAM.
- Accepts ASCII bytes over a valid/ready handshake, tracks a cursor, and issues single-cycle write commands (we/addr/data) straight into the video RAM write port.
- Interprets a small set of control codes: CR, LF, BS and FF (clear screen).
- Its RAM-side ports connect one-to-one to the RAM's clk/write_en/addr/din.

Parameters:
- cols, 40, characters per row
- rows, 30, rows per screen
- addr_width, 11, RAM address width; must satisfy rows*cols <= 2**addr_width
- data_width, 8, character code width
- FILL_CHAR, 8'h20, code written by clear and backspace
- CLEAR_ON_RESET, 1, if 1 a full-screen clear runs automatically after reset release

Ports:
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  synchronous active-low reset
- char_in  in  data_width  incoming character code
- char_valid  in  1  char_in valid
- char_ready  out  1  block can accept char_in this cycle
- ram_we  out  1  write strobe to video RAM
- ram_addr  out  addr_width  video RAM address
- ram_din  out  data_width  video RAM write data
- cursor_col  out  6  current column, 0..cols-1
- cursor_row  out  5  current row, 0..rows-1
- busy  out  1  high while the CLEAR sequence runs

Behaviour:
- Reset (rstn=0 at a clk edge):
  - cursor_col=0, cursor_row=0.
  - ram_we=0, ram_addr=0, ram_din=0, busy=0.
  - char_ready=0 while rstn=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - Reset asserted mid-CLEAR or mid-WRITE aborts the operation; no further RAM write is issued.
- States: IDLE, WRITE, CLEAR.
- IDLE:
  - char_ready=1, ram_we=0.
  - A transfer occurs on an edge with char_valid=1 and char_ready=1.
- Accepted printable code 0x20..0x7E:
  - Next cycle is WRITE: ram_we=1, ram_addr=row*cols+col (old cursor), ram_din=char.
  - Cursor advances at the same edge that enters WRITE.
  - Then returns to IDLE.
  - Throughput: 1 character per 2 cycles; char_ready=0 during WRITE.
- Cursor advance:
  - col+1.
  - If col was cols-1: col=0, row+1.
  - If row was rows-1: row=0 (wrap to top; no scrolling).
- 0x0D CR: col=0, no write, stay IDLE.
- 0x0A LF: col=0, row+1 with the same wrap rule, no write.
- 0x08 BS:
  - If col>0: col-1, then WRITE FILL_CHAR at the new position.
  - If col=0: no-op (no row back-up).
- 0x0C FF:
  - Enter CLEAR, busy=1, char_ready=0.
  - Writes FILL_CHAR to addresses 0,1,...,rows*cols-1, one per cycle, ram_we=1 each cycle.
  - After the write to rows*cols-1: cursor=(0,0), busy=0, return to IDLE. IDLE is entered on the following edge.
  - Total duration: rows*cols cycles with we high.
- All other codes (0x00..0x1F not listed, 0x7F..0xFF): consumed, no write, cursor unchanged.
- Outputs are registered. ram_addr/ram_din hold their last value when ram_we=0.
- Address arithmetic:
  - Computed modulo 2**addr_width.
  - Implementation may keep a running linear address instead of multiplying, but must always equal row*cols+col.
- The RAM's read-during-write value is irrelevant to this block; it never reads.

Test Plan (cols=40, rows=30, CLEAR_ON_RESET=1):
- Reset release -> busy=1 for exactly 1200 cycles; ram_we=1 with addresses 0..1199 and data 0x20; then busy=0, char_ready=1, cursor (0,0).
- After clear, send 'A','B' back-to-back -> writes addr 0 = 0x41, addr 1 = 0x42; char_ready low one cycle after each accept; cursor (2,0).
- Cursor at (39,29), send 'Z' -> write addr 1199 = 0x5A; cursor wraps to (0,0).
- Cursor at (5,3), send 0x08 -> write addr 124 = 0x20, cursor (4,3). At (0,3), send 0x08 -> no write, cursor unchanged.
- Cursor at (7,29), send 0x0A -> cursor (0,0), no write. At (7,2), send 0x0D -> cursor (0,2), no write. Send 0x07 -> no write, cursor unchanged.
- Send 0x0C; pull rstn low at clear address 500 -> no ram_we on or after the reset edge; cursor (0,0); a new clear starts after rstn returns high.
